dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the CPU datapath's load/store interface.
- Accepts one word request (address, write-enable, write data) from the datapath's ALU-result/write-data side.
- Returns read data or write completion after a fixed programmable latency.
- Contains a word-addressed storage array and a request/response state machine.

Parameters:
- n, 32, data and address width in bits.
- DEPTH, 64, storage size in words; must be a power of two, 4..1024.
- LATENCY, 2, cycles from request acceptance to the ready pulse; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; captured with req.
- addr  input  n  byte address; captured with req.
- wdata  input  n  store data; captured with req.
- ready  output  1  one-cycle pulse marking response/completion.
- rdata  output  n  load result; registered.
- err  output  1  error flag, valid while ready=1.
- busy  output  1  high while a request is in flight (WAIT or RESP).

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; ready=0, err=0, busy=0, rdata=0.
  - All DEPTH words cleared to 0.
  - Counter cleared.
  - Reset wins over any other event.
  - A request in flight is aborted; its pending write is discarded.
- States are IDLE, WAIT and RESP.
- IDLE:
  - req=1 captures we, addr and wdata into holding registers.
  - Counter is loaded with LATENCY-1.
  - Next state is WAIT, or RESP directly when LATENCY=1.
  - req=0: stay in IDLE.
- WAIT:
  - busy=1; counter decrements each cycle.
  - Moves to RESP on the cycle after the counter reads 0.
  - req is ignored.
- RESP:
  - ready=1 and busy=1 for exactly one cycle; next state is always IDLE.
  - req is ignored here, even if held high.
  - A new request can be accepted in IDLE on the following cycle.
- Timing:
  - A request accepted at edge T gives ready=1 during the cycle after edge T+LATENCY.
  - Maximum throughput is one request per LATENCY+1 cycles.
- Indexing:
  - Word index = addr[log2(DEPTH)+1:2].
  - Address bits above the index field are ignored, so addresses alias modulo DEPTH*4.
- Errors:
  - Captured addr[1:0] != 0 sets err=1 during RESP.
  - On error, a store is suppressed and rdata is forced to 0.
- Load: the array word is registered into rdata on entry to RESP.
- Store:
  - The array is written at the edge entering RESP.
  - rdata is unchanged on a store.
- rdata holds its last value outside RESP until the next load or reset.
- A load to the address of the immediately preceding store returns the new data; there is no hazard window.

Optional Feature:
- DMEM_BYTE_LANES_EN defined:
  - Adds port be (input, 4 bits), captured with req.
  - A store writes only the bytes whose be bit is set; be[0] selects bits 7:0.
  - be=4'b0000 on a store gives err=1 and no write.
  - Loads ignore be.
  - The alignment check is unchanged.
- Not defined: no be port; stores write the full word.

Decomposition:
- Package dmem_pkg:
  - state enum typedef dmem_state_t (IDLE, WAIT, RESP).
  - Counter width constant LAT_W=4.
  - Index-width function clog2-based.
- One sub-module, dmem_lat_counter: a loadable 4-bit down-counter with a zero flag, used by the FSM.
- Storage array and FSM stay in dmem_responder.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset=0 for 2 cycles, then reset=1 with req=0 for 5 cycles.
  - Response: ready=0, busy=0, rdata=0 throughout; a load from 0x0 afterwards returns 0.
- Store/load round trip, LATENCY=2:
  - Stimulus: store 0xDEADBEEF to 0x10, then load 0x10.
  - Response: each ready arrives exactly 2 cycles after acceptance; rdata=0xDEADBEEF, err=0.
- Misaligned access:
  - Stimulus: store 0x12345678 to 0x22, then load 0x20.
  - Response: err=1 on the store; the load returns the prior contents (0 after reset), err=0.
- Aliasing and ignored req:
  - Stimulus: store 0xA5A5A5A5 to 0x04 with DEPTH=64; hold req=1 through WAIT and RESP; then load 0x104.
  - Response: exactly one response for the held request; the load returns 0xA5A5A5A5.
- Reset mid-operation:
  - Stimulus: store 0x55 to 0x08, then assert reset during WAIT.
  - Response: no ready pulse; a load from 0x08 after reset returns 0.
- Byte lanes (DMEM_BYTE_LANES_EN):
  - Stimulus: word 0x11223344 at 0x0; store 0xAABBCCDD with be=4'b0101, then load 0x0.
  - Response: the load returns 0x11BB33DD; a store with be=0 gives err=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and helpers for the data-memory responder slice.
//   dmem_state_t : request/response FSM states (IDLE, WAIT, RESP)
//   LAT_W        : width of the latency down-counter
//   idx_width()  : number of word-index bits needed for a given depth
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int LAT_W = 4;

  // A depth of 1 would need zero index bits; clamp so slices stay legal.
  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_lat_counter.sv
// dmem_lat_counter
// Loadable down-counter that times the WAIT phase of the responder FSM.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous, active-low reset (clears the count)
//   load     : load load_val on the next edge (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one on the next edge
//   zero     : high while the count reads zero
module dmem_lat_counter
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side end of the datapath load/store interface. One word request is
// captured in IDLE, timed through WAIT by a latency counter, and answered with
// a one-cycle ready pulse in RESP. Storage is a word-addressed array.
//
// Optional build macro: DMEM_BYTE_LANES_EN adds a 4-bit byte-enable port for
// stores (be[0] selects bits 7:0; be=0 on a store is an error).
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low reset
//   req    : request strobe, sampled only in IDLE
//   we     : 1 = store, 0 = load
//   addr   : byte address (word index = addr[log2(DEPTH)+1:2])
//   wdata  : store data
//   be     : store byte enables (only with DMEM_BYTE_LANES_EN)
//   ready  : one-cycle response pulse
//   rdata  : registered load result
//   err    : error flag, valid while ready=1
//   busy   : high while a request is in WAIT or RESP
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int n       = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
`ifdef DMEM_BYTE_LANES_EN
  input  logic [3:0]   be,
`endif
  output logic         ready,
  output logic [n-1:0] rdata,
  output logic         err,
  output logic         busy
);

  localparam int IDX_W = idx_width(DEPTH);

  dmem_state_t       state;
  logic              hold_we;
  logic [IDX_W+1:0]  hold_addr;
  logic [n-1:0]      hold_wdata;
`ifdef DMEM_BYTE_LANES_EN
  logic [3:0]        hold_be;
`endif
  logic [n-1:0]      mem [DEPTH];

  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  logic              acc_we;
  logic [IDX_W+1:0]  acc_addr;
  logic [n-1:0]      acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_err;
  logic [n-1:0]      wmask;
  logic              enter_resp;

  // Address bits above the index field alias and are intentionally dropped.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^addr[n-1:IDX_W+2];

  dmem_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_W'(LATENCY - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign cnt_load = (state == IDLE) && req;
  assign cnt_dec  = (state == WAIT) && !cnt_zero;

  // The access happens on the edge that enters RESP. With LATENCY=1 that is
  // the accepting edge itself, so the live inputs are used instead of the
  // holding registers, which are only being loaded on that same edge.
  always_comb begin
    acc_we    = hold_we;
    acc_addr  = hold_addr;
    acc_wdata = hold_wdata;
    if (state == IDLE) begin
      acc_we    = we;
      acc_addr  = addr[IDX_W+1:0];
      acc_wdata = wdata;
    end
    acc_idx = acc_addr[IDX_W+1:2];

    wmask   = '1;
    acc_err = (acc_addr[1:0] != 2'b00);
`ifdef DMEM_BYTE_LANES_EN
    begin
      logic [3:0] acc_be;
      acc_be = (state == IDLE) ? be : hold_be;
      wmask  = '0;
      for (int b = 0; b < 4; b++) begin
        if (((b * 8) + 8) <= n && acc_be[b]) begin
          wmask[b*8 +: 8] = '1;
        end
      end
      if (acc_we && (acc_be == 4'b0000)) begin
        acc_err = 1'b1;
      end
    end
`endif

    enter_resp = ((state == IDLE) && req && (LATENCY == 1)) ||
                 ((state == WAIT) && cnt_zero);
  end

  // Request/response FSM, storage array and registered outputs. Reset clears
  // everything, including the array, and so discards any in-flight store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ready      <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
`ifdef DMEM_BYTE_LANES_EN
      hold_be    <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            hold_we    <= we;
            hold_addr  <= addr[IDX_W+1:0];
            hold_wdata <= wdata;
`ifdef DMEM_BYTE_LANES_EN
            hold_be    <= be;
`endif
            busy       <= 1'b1;
            state      <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        ready <= 1'b1;
        err   <= acc_err;
        if (acc_err) begin
          rdata <= '0;
        end else if (acc_we) begin
          mem[acc_idx] <= (mem[acc_idx] & ~wmask) | (acc_wdata & wmask);
        end else begin
          rdata <= mem[acc_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed, table-driven bench for dmem_responder (n=32, DEPTH=64,
// LATENCY=2). Define DMEM_BYTE_LANES_EN for both bench and RTL to exercise
// the byte-lane stores.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  int checks;
  int errors;

  dmem_responder #(
    .n       (32),
    .DEPTH   (64),
    .LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
`ifdef DMEM_BYTE_LANES_EN
    .be    (be),
`endif
    .ready (ready),
    .rdata (rdata),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one transaction from IDLE, returning the response and the number of
  // edges from acceptance to the ready pulse (capped at 20 on timeout).
  task automatic applyStimulus(input logic t_we, input logic [31:0] t_addr,
                               input logic [31:0] t_wdata, input logic [3:0] t_be,
                               output logic got_err, output logic [31:0] got_rdata,
                               output logic got_busy, output int lat,
                               output logic post_ready, output logic post_busy);
    req   = 1'b1;
    we    = t_we;
    addr  = t_addr;
    wdata = t_wdata;
    be    = t_be;
    step();
    req = 1'b0;
    lat = 0;
    while (!ready && lat < 20) begin
      step();
      lat++;
    end
    got_err   = err;
    got_rdata = rdata;
    got_busy  = busy;
    step();
    post_ready = ready;
    post_busy  = busy;
  endtask

  // Full transaction with latency, busy and response checks.
  task automatic access(input string name, input logic t_we, input logic [31:0] t_addr,
                        input logic [31:0] t_wdata, input logic [3:0] t_be,
                        input logic exp_err, input logic [31:0] exp_rdata);
    logic        g_err;
    logic [31:0] g_rdata;
    logic        g_busy;
    int          g_lat;
    logic        p_ready;
    logic        p_busy;
    applyStimulus(t_we, t_addr, t_wdata, t_be, g_err, g_rdata, g_busy, g_lat,
                  p_ready, p_busy);
    checkOutput({name, "_latency"}, 32'(g_lat), 32'(LAT));
    checkOutput({name, "_err"}, {31'b0, g_err}, {31'b0, exp_err});
    checkOutput({name, "_rdata"}, g_rdata, exp_rdata);
    checkOutput({name, "_busy_resp"}, {31'b0, g_busy}, 32'd1);
    checkOutput({name, "_ready_after"}, {31'b0, p_ready}, 32'd0);
    checkOutput({name, "_busy_after"}, {31'b0, p_busy}, 32'd0);
  endtask

  initial begin
    int ready_count;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req    = 1'b0;
    we     = 1'b0;
    addr   = '0;
    wdata  = '0;
    be     = 4'hF;

    // Directed vectors in execution order; rdata expectations follow the
    // previous load because stores leave rdata untouched.
    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  1'b0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0011, 32'h0,          1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b1, 32'h0000_0022, 32'h1234_5678,  1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0,          1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D,  1'b0, 32'h0000_0000};
    vecs[7]  = '{1'b0, 32'h0000_01FC, 32'h0,          1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h0000_003C, 32'h0BAD_F00D,  1'b0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 32'h0000_013C, 32'h0,          1'b0, 32'h0BAD_F00D};
    vecs[10] = '{1'b0, 32'hFFFF_FF10, 32'h0,          1'b0, 32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 32'h0000_0013, 32'h0,          1'b1, 32'h0000_0000};

    // Reset held for two edges, then idle with req low.
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput($sformatf("rst%0d_ready", i), {31'b0, ready}, 32'd0);
      checkOutput($sformatf("rst%0d_busy", i), {31'b0, busy}, 32'd0);
      checkOutput($sformatf("rst%0d_rdata", i), rdata, 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput($sformatf("idle%0d_ready", i), {31'b0, ready}, 32'd0);
      checkOutput($sformatf("idle%0d_busy", i), {31'b0, busy}, 32'd0);
      checkOutput($sformatf("idle%0d_rdata", i), rdata, 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             4'hF, vecs[i].exp_err, vecs[i].exp_rdata);
    end

    // Request held high through WAIT and RESP yields a single response.
    $display("[TB] held request sequence");
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h0000_0004;
    wdata = 32'hA5A5_A5A5;
    be    = 4'hF;
    step();
    ready_count = 0;
    for (int k = 0; k < LAT + 1; k++) begin
      step();
      if (ready) ready_count++;
    end
    req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (ready) ready_count++;
    end
    checkOutput("held_req_responses", 32'(ready_count), 32'd1);
    access("alias_load", 1'b0, 32'h0000_0104, 32'h0, 4'hF, 1'b0, 32'hA5A5_A5A5);

    // Reset during WAIT aborts the store.
    $display("[TB] reset mid-operation sequence");
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h0000_0008;
    wdata = 32'h0000_0055;
    step();
    req   = 1'b0;
    reset = 1'b0;
    step();
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_rdata", rdata, 32'd0);
    reset = 1'b1;
    ready_count = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ready) ready_count++;
    end
    checkOutput("midrst_no_ready", 32'(ready_count), 32'd0);
    access("midrst_load08", 1'b0, 32'h0000_0008, 32'h0, 4'hF, 1'b0, 32'h0);
    access("midrst_load10", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 32'h0);

`ifdef DMEM_BYTE_LANES_EN
    $display("[TB] byte lane sequence");
    access("be_full",  1'b1, 32'h0, 32'h1122_3344, 4'hF,    1'b0, 32'h0);
    access("be_0101",  1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
    access("be_load",  1'b0, 32'h0, 32'h0,         4'b0000, 1'b0, 32'h11BB_33DD);
    access("be_zero",  1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0000, 1'b1, 32'h0);
    access("be_load2", 1'b0, 32'h0, 32'h0,         4'hF,    1'b0, 32'h11BB_33DD);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
